// File: rtl/mac_fixed_stream.sv
// Streaming signed fixed-point MAC: accumulates in_1*in_2 over an in_last-delimited vector, emits one rounded/saturated result.
// Latency: the in_last element accepted at edge t produces out_valid after edge t+1 (2 cycles); 1 element/cycle throughput.
// Backpressure: a held result (out_valid && !out_ready) freezes the whole pipeline and drops in_ready combinationally.
module mac_fixed_stream #(
  parameter int T_WIDTH   = 32,
  parameter int ACC_WIDTH = 80,
  parameter int FRAC_0    = 0,
  parameter int FRAC_1    = 16,
  parameter int FRAC_2    = 8,
  parameter int FRAC_3    = 24,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [T_WIDTH-1:0]   in_1,
  input  logic [T_WIDTH-1:0]   in_2,
  input  logic                 in_last,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [T_WIDTH-1:0]   out,
  output logic [LEN_WIDTH-1:0] out_len,
  output logic                 out_sat,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int PW = 2 * T_WIDTH;
  localparam logic [LEN_WIDTH-1:0] CNT_MAX = '1;
  // Representable T_WIDTH range, sign-extended to accumulator width for comparison.
  localparam logic signed [ACC_WIDTH-1:0] RES_MAX =
    {{(ACC_WIDTH-T_WIDTH+1){1'b0}}, {(T_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] RES_MIN =
    {{(ACC_WIDTH-T_WIDTH+1){1'b1}}, {(T_WIDTH-1){1'b0}}};

  logic en, accept;
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign accept   = in_valid && en;

  // Input-side vector tracking: mode is captured only on the first element of a vector.
  logic       in_first;
  logic [1:0] mode_lat, mode_cur;
  assign mode_cur = in_first ? mode : mode_lat;

  // Track vector start and hold the mode chosen by the first element.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_first <= 1'b1;
      mode_lat <= 2'd0;
    end else if (accept) begin
      in_first <= in_last;
      mode_lat <= mode_cur;
    end
  end

  // Full-width signed product; operands sign-extended so the multiply is exact.
  logic signed [PW-1:0] prod;
  assign prod = $signed({{T_WIDTH{in_1[T_WIDTH-1]}}, in_1}) *
                $signed({{T_WIDTH{in_2[T_WIDTH-1]}}, in_2});

  logic signed [PW-1:0] p_reg;
  logic                 p_valid, p_last;
  logic [1:0]           p_mode;

  // Stage 1: register product and element tags; frozen while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_reg   <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      p_mode  <= 2'd0;
    end else if (en) begin
      p_reg   <= prod;
      p_valid <= accept;
      p_last  <= in_last;
      p_mode  <= mode_cur;
    end
  end

  logic signed [ACC_WIDTH-1:0] acc, acc_next, p_ext, rnd, r_sum, r_shift;
  logic [LEN_WIDTH-1:0]        cnt, cnt_next;
  logic                        first;
  logic                        sat_hi, sat_lo;
  logic [T_WIDTH-1:0]          res;
  int                          frac;

  // Stage 2 datapath: accumulate, then round-half-up, shift by F and clip.
  always_comb begin
    p_ext    = {{(ACC_WIDTH-PW){p_reg[PW-1]}}, p_reg};
    acc_next = first ? p_ext : acc + p_ext;
    cnt_next = first ? LEN_WIDTH'(1) : ((cnt == CNT_MAX) ? cnt : cnt + LEN_WIDTH'(1));
    case (p_mode)
      2'd0:    frac = FRAC_0;
      2'd1:    frac = FRAC_1;
      2'd2:    frac = FRAC_2;
      default: frac = FRAC_3;
    endcase
    rnd = '0;
    if (frac > 0) rnd = ACC_WIDTH'(1) << (frac - 1);
    r_sum   = acc_next + rnd;
    r_shift = r_sum >>> frac;
    sat_hi  = r_shift > RES_MAX;
    sat_lo  = r_shift < RES_MIN;
    if (sat_hi)      res = RES_MAX[T_WIDTH-1:0];
    else if (sat_lo) res = RES_MIN[T_WIDTH-1:0];
    else             res = r_shift[T_WIDTH-1:0];
  end

  // Stage 2 state: accumulator, element count and vector-start flag advance per valid product.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      first <= 1'b1;
    end else if (en && p_valid) begin
      acc   <= acc_next;
      cnt   <= cnt_next;
      first <= p_last;
    end
  end

  // Output register: load on vector end (even while popping), otherwise clear on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_len   <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else if (en && p_valid && p_last) begin
      out       <= res;
      out_len   <= cnt_next;
      out_sat   <= sat_hi || sat_lo;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_fixed_stream.sv
// Self-checking bench for mac_fixed_stream: directed vectors with a result scoreboard.
// Expected {out, out_len, out_sat} are pushed when the last element is driven and popped on each output handshake.
// Scenario tasks also check reset state, latency, back-pressure and reset-mid-vector behaviour inline.
module tb_mac_fixed_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_1, in_2;
  logic        in_last;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out;
  logic [15:0] out_len;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready;

  int vectors     = 0;
  int miscompares = 0;

  logic [48:0] exp_q[$];

  mac_fixed_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_1      (in_1),
    .in_2      (in_2),
    .in_last   (in_last),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_len   (out_len),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Scoreboard: compare every output handshake against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_result got out=%h len=%0d sat=%b, queue empty", out, out_len, out_sat);
      end else begin
        logic [48:0] e;
        e = exp_q.pop_front();
        if ({out, out_len, out_sat} !== e)
          begin
            miscompares++;
            $display("FAIL result got out=%h len=%0d sat=%b, want out=%h len=%0d sat=%b",
                     out, out_len, out_sat, e[48:17], e[16:1], e[0]);
          end
      end
    end
  end

  task automatic expect_result(input logic [31:0] o, input logic [15:0] l, input logic s);
    exp_q.push_back({o, l, s});
  endtask

  // Present one element and hold it until accepted; returns number of stalled cycles.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last,
                      input logic [1:0] m, output int waits);
    logic ok;
    in_1 = a; in_2 = b; in_last = last; mode = m; in_valid = 1'b1;
    waits = 0;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (!ok) waits++;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout element a=%h b=%h never accepted within 50 cycles", a, b);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been observed.
  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout %0d results still outstanding, want 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if (out !== 32'h0) begin miscompares++; $display("FAIL reset_out got %h want 0", out); end
    vectors++; if (out_len !== 16'h0) begin miscompares++; $display("FAIL reset_out_len got %0d want 0", out_len); end
    vectors++; if (out_sat !== 1'b0) begin miscompares++; $display("FAIL reset_out_sat got %b want 0", out_sat); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_dot_product();
    int w;
    send(32'd1, 32'd4, 1'b0, 2'd0, w);
    send(32'd2, 32'd5, 1'b0, 2'd0, w);
    expect_result(32'd32, 16'd3, 1'b0);
    send(32'd3, 32'd6, 1'b1, 2'd0, w);
    idle();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL latency_early out_valid got %b want 0 one cycle after last", out_valid); end
    @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL latency out_valid got %b want 1 two cycles after last", out_valid); end
    drain();
  endtask

  task automatic test_rounding();
    int w;
    expect_result(32'h0003_0000, 16'd1, 1'b0);
    send(32'h0001_8000, 32'h0002_0000, 1'b1, 2'd1, w);
    expect_result(32'h0000_0001, 16'd1, 1'b0);
    send(32'h0000_0001, 32'h0000_8000, 1'b1, 2'd1, w);
    expect_result(32'h0000_0000, 16'd1, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_8000, 1'b1, 2'd1, w);
    // Q8: 1.0 * 2.5 = 2.5
    expect_result(32'h0000_0280, 16'd1, 1'b0);
    send(32'h0000_0100, 32'h0000_0280, 1'b1, 2'd2, w);
    // Q24: -0.5 * 1.0 = -0.5
    expect_result(32'hFF80_0000, 16'd1, 1'b0);
    send(32'hFF80_0000, 32'h0100_0000, 1'b1, 2'd3, w);
    idle();
    drain();
  endtask

  task automatic test_saturation();
    int w;
    expect_result(32'h7FFF_FFFF, 16'd1, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0002, 1'b1, 2'd0, w);
    expect_result(32'h8000_0000, 16'd1, 1'b1);
    send(32'h8000_0000, 32'h0000_0002, 1'b1, 2'd0, w);
    // Exactly at the negative bound is not a clip.
    expect_result(32'h8000_0000, 16'd1, 1'b0);
    send(32'hC000_0000, 32'h0000_0002, 1'b1, 2'd0, w);
    idle();
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    logic [4:0] ov;
    expect_result(32'd1, 16'd1, 1'b0);
    expect_result(32'd4, 16'd1, 1'b0);
    expect_result(32'd9, 16'd1, 1'b0);
    send(32'd1, 32'd1, 1'b1, 2'd0, w);
    vectors++; if (w !== 0) begin miscompares++; $display("FAIL b2b_stall1 waits got %0d want 0", w); end
    ov[0] = out_valid;
    send(32'd2, 32'd2, 1'b1, 2'd0, w);
    vectors++; if (w !== 0) begin miscompares++; $display("FAIL b2b_stall2 waits got %0d want 0", w); end
    ov[1] = out_valid;
    send(32'd3, 32'd3, 1'b1, 2'd0, w);
    vectors++; if (w !== 0) begin miscompares++; $display("FAIL b2b_stall3 waits got %0d want 0", w); end
    ov[2] = out_valid;
    idle();
    @(posedge clk);
    #1;
    ov[3] = out_valid;
    @(posedge clk);
    #1;
    ov[4] = out_valid;
    vectors++;
    if (ov !== 5'b01110) begin
      miscompares++;
      $display("FAIL b2b_out_valid_pattern got %b want 01110 (msb=latest)", ov);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int w;
    out_ready = 1'b0;
    expect_result(32'd7, 16'd1, 1'b0);
    send(32'd1, 32'd7, 1'b1, 2'd0, w);
    expect_result(32'd6, 16'd1, 1'b0);
    send(32'd2, 32'd3, 1'b1, 2'd0, w);
    expect_result(32'd16, 16'd1, 1'b0);
    in_1 = 32'd4; in_2 = 32'd4; in_last = 1'b1; mode = 2'd0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready); end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid cycle %0d got %b want 1", i, out_valid); end
      vectors++; if (out !== 32'd7) begin miscompares++; $display("FAIL bp_out_held cycle %0d got %h want 7", i, out); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    idle();
    drain();
  endtask

  task automatic test_reset_mid_vector();
    int w;
    send(32'd7, 32'd7, 1'b0, 2'd0, w);
    send(32'd8, 32'd8, 1'b0, 2'd0, w);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_result(32'd25, 16'd1, 1'b0);
    send(32'd5, 32'd5, 1'b1, 2'd0, w);
    // Mode flips to Q16 on the last element; the vector keeps its integer format.
    send(32'd2, 32'd3, 1'b0, 2'd0, w);
    expect_result(32'd26, 16'd2, 1'b0);
    send(32'd4, 32'd5, 1'b1, 2'd1, w);
    idle();
    drain();
  endtask

  initial begin
    rst = 1'b1; in_1 = '0; in_2 = '0; in_last = 1'b0; mode = 2'd0;
    in_valid = 1'b0; out_ready = 1'b1;
    test_reset();
    test_dot_product();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_vector();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
